hub75_scan_ctrl: RTL



---
 rtl/hub75_pkg.sv | 18 +
 rtl/hub75_oe_timer.sv | 41 ++++
 rtl/hub75_scan_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants, state codes and on-time scaling for the HUB75 scan controller
package hub75_pkg;
  localparam int PANEL_COLS = 60;
  localparam int PANEL_ROWS = 16;
  localparam int COL_W = 7;
  localparam int ROW_W = 4;
  localparam int CNT_W = 12;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_BLANK = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  function automatic logic [CNT_W-1:0] scale_on(input logic [CNT_W-1:0] on, input logic [3:0] b);
    logic [CNT_W+3:0] p;
    p = {4'd0, on} * {{(CNT_W){1'b0}}, b};
    return p[CNT_W+3:4];
  endfunction
endpackage

// File: rtl/hub75_oe_timer.sv
// hub75_oe_timer: per-line on-time counter driving the registered active-low output enable (SCAN_BRIGHTNESS_EN adds bright scaling)
module hub75_oe_timer
  import hub75_pkg::*;
#(
  parameter int ON_TIME = 100
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic       sample,
  input  logic [3:0] bright,
`endif
  input  logic       clr,
  input  logic       valid_nx,
  output logic       done,
  output logic       oe_n
);
  localparam logic [CNT_W-1:0] ON = CNT_W'(ON_TIME);
  logic [CNT_W-1:0] cnt, cnt_nx, eff_nx;
  assign cnt_nx = clr ? '0 : (cnt < ON ? cnt + 1'b1 : cnt);
  assign done = cnt == ON;
`ifdef SCAN_BRIGHTNESS_EN
  logic [CNT_W-1:0] eff;
  assign eff_nx = sample ? scale_on(ON, bright) : eff;
  // brightness captured at latch time so it only affects the following line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) eff <= '0;
    else eff <= eff_nx;
`else
  assign eff_nx = ON;
`endif
  // counter saturates at ON_TIME; oe_n is precomputed from next-cycle values so it stays registered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      oe_n <= 1'b1;
    end else begin
      cnt  <= cnt_nx;
      oe_n <= !(valid_nx && cnt_nx < eff_nx);
    end
endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: overlapped-scan sequencer for a HUB75 panel (optional SCAN_BRIGHTNESS_EN adds bright input)
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROWS      = PANEL_ROWS,
  parameter int ON_TIME   = 100,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]       bright,
`endif
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             sclk,
  output logic             lat,
  output logic             oe_n,
  output logic [ROW_W-1:0] addr,
  output logic             frame_done
);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
  logic [2:0] state, state_nx;
  logic [COL_W-1:0] col_nx;
  logic [ROW_W-1:0] row_nx;
  logic [7:0] bcnt, bcnt_nx;
  logic phase, phase_nx, valid, valid_nx, clr, done, last_col, last_row;
  assign last_col = col == COL_W'(COLS - 1);
  assign last_row = row == ROW_W'(ROWS - 1);
  hub75_oe_timer #(.ON_TIME(ON_TIME)) u_oe (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SCAN_BRIGHTNESS_EN
    .sample   (state == S_LATCH),
    .bright   (bright),
`endif
    .clr      (clr),
    .valid_nx (valid_nx),
    .done     (done),
    .oe_n     (oe_n)
  );
  // line sequencing: shift pixels, wait out the on-time, blank, latch
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    phase_nx = phase;
    valid_nx = valid;
    bcnt_nx  = bcnt;
    clr      = 1'b0;
    case (state)
      S_IDLE: begin
        valid_nx = 1'b0;
        state_nx = en ? S_SHIFT : S_IDLE;
        col_nx   = '0;
        phase_nx = 1'b0;
        clr      = en;
      end
      S_SHIFT: begin
        phase_nx = !phase;
        if (phase) begin
          col_nx   = last_col ? '0 : col + 1'b1;
          state_nx = last_col ? S_WAIT : S_SHIFT;
        end
      end
      S_WAIT: begin
        state_nx = done ? S_BLANK : S_WAIT;
        bcnt_nx  = '0;
      end
      S_BLANK: begin
        bcnt_nx  = bcnt + 1'b1;
        state_nx = bcnt == BLANK_LAST ? S_LATCH : S_BLANK;
      end
      S_LATCH: begin
        valid_nx = 1'b1;
        row_nx   = last_row ? '0 : row + 1'b1;
        state_nx = en ? S_SHIFT : S_IDLE;
        col_nx   = '0;
        phase_nx = 1'b0;
        clr      = en;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // state and panel outputs; outputs derive from next-state so they align with the state they describe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      valid      <= 1'b0;
      bcnt       <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      phase      <= phase_nx;
      valid      <= valid_nx;
      bcnt       <= bcnt_nx;
      sclk       <= state_nx == S_SHIFT && phase_nx;
      lat        <= state_nx == S_LATCH;
      addr       <= state_nx == S_LATCH ? row : addr;
      frame_done <= state_nx == S_LATCH && last_row;
    end
endmodule
